// File: rtl/sda_kernel_param_pkg.sv
// rtl/sda_kernel_param_pkg.sv - register map, response codes and control FSM states
package sda_kernel_param_pkg;

    localparam logic [9:0] CTRL_OFFSET = 10'h000;
    localparam logic [9:0] PARAM_BASE  = 10'h010;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_IDLE_BIT  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GO   = 2'd1,
        ST_RUN  = 2'd2
    } ctrl_state_t;

    // Word index of a PARAM offset; only meaningful once offset >= PARAM_BASE.
    function automatic logic [7:0] param_index(input logic [9:0] offset);
        return 8'((offset - PARAM_BASE) >> 2);
    endfunction

endpackage

// File: rtl/sda_param_lookup_stage.sv
// rtl/sda_param_lookup_stage.sv - one-entry SELF response register over the parameter array
module sda_param_lookup_stage
    import sda_kernel_param_pkg::*;
#(
    parameter int PARAM_WORDS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PARAM_WORDS-1:0][31:0] params,
    input  logic                        paramaddr_0Ready,
    output logic                        paramaddr_0Stop,
    input  logic [31:0]                 paramaddr_0Data,
    output logic                        paramdata_0Ready,
    input  logic                        paramdata_0Stop,
    output logic [31:0]                 paramdata_0Data
);

    logic        pending_q;
    logic [31:0] data_q;
    logic [31:0] lookup_word;
    logic        accept;

    // A new request may replace the held response on the very edge it drains.
    assign paramaddr_0Stop = pending_q && paramdata_0Stop;
    assign accept          = paramaddr_0Ready && !paramaddr_0Stop;

    always_comb begin
        lookup_word = '0;
        for (int i = 0; i < PARAM_WORDS; i++) begin
            if (paramaddr_0Data == 32'(i)) begin
                lookup_word = params[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            data_q    <= '0;
        end else if (accept) begin
            pending_q <= 1'b1;
            data_q    <= lookup_word;
        end else if (!paramdata_0Stop) begin
            pending_q <= 1'b0;
        end
    end

    assign paramdata_0Ready = pending_q;
    assign paramdata_0Data  = data_q;

endmodule

// File: rtl/sda_kernel_param_regs.sv
// rtl/sda_kernel_param_regs.sv - AXI-lite kernel control/parameter registers with SELF go/done/lookup ports
module sda_kernel_param_regs
    import sda_kernel_param_pkg::*;
#(
    parameter int PARAM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic        go_0Ready,
    input  logic        go_0Stop,
    input  logic        done_0Ready,
    output logic        done_0Stop,
    input  logic        paramaddr_0Ready,
    output logic        paramaddr_0Stop,
    input  logic [31:0] paramaddr_0Data,
    output logic        paramdata_0Ready,
    input  logic        paramdata_0Stop,
    output logic [31:0] paramdata_0Data
);

    ctrl_state_t                  state_q, state_d;
    logic [PARAM_WORDS-1:0][31:0] params_q;
    logic                         done_q;
    logic                         rvalid_q, bvalid_q;
    logic [31:0]                  rdata_q;
    logic [1:0]                   rresp_q, bresp_q;

    logic [9:0]  rd_off, wr_off;
    logic        rd_accept, wr_accept;
    logic        rd_is_ctrl, rd_is_param, wr_is_ctrl, wr_is_param;
    logic        start_req, param_wr_ok;
    logic [31:0] ctrl_value, rd_param_word;
    logic        unused_addr_bits;

    assign rd_off = s_axi_araddr[9:0];
    assign wr_off = s_axi_awaddr[9:0];
    assign unused_addr_bits = ^{s_axi_araddr[31:10], s_axi_awaddr[31:10]};

    assign s_axi_arready = s_axi_arvalid && !rvalid_q;
    assign rd_accept     = s_axi_arready;
    assign s_axi_awready = s_axi_awvalid && s_axi_wvalid && !bvalid_q;
    assign s_axi_wready  = s_axi_awready;
    assign wr_accept     = s_axi_awready;

    assign rd_is_ctrl  = rd_off == CTRL_OFFSET;
    assign rd_is_param = (rd_off >= PARAM_BASE) && (rd_off[1:0] == 2'b00)
                         && (param_index(rd_off) < 8'(PARAM_WORDS));
    assign wr_is_ctrl  = wr_off == CTRL_OFFSET;
    assign wr_is_param = (wr_off >= PARAM_BASE) && (wr_off[1:0] == 2'b00)
                         && (param_index(wr_off) < 8'(PARAM_WORDS));

    assign start_req   = wr_accept && wr_is_ctrl && s_axi_wstrb[0] && s_axi_wdata[CTRL_START_BIT];
    // Parameters are frozen while the kernel owns them.
    assign param_wr_ok = wr_accept && wr_is_param && (state_q == ST_IDLE);

    always_comb begin
        ctrl_value                 = '0;
        ctrl_value[CTRL_START_BIT] = state_q == ST_GO;
        ctrl_value[CTRL_DONE_BIT]  = done_q;
        ctrl_value[CTRL_IDLE_BIT]  = state_q == ST_IDLE;
    end

    always_comb begin
        rd_param_word = '0;
        for (int i = 0; i < PARAM_WORDS; i++) begin
            if (param_index(rd_off) == 8'(i)) begin
                rd_param_word = params_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        go_0Ready  = 1'b0;
        done_0Stop = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (start_req) state_d = ST_GO;
            end
            ST_GO: begin
                go_0Ready = 1'b1;
                if (!go_0Stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                done_0Stop = 1'b0;
                if (done_0Ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            params_q <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            // A completion landing on the same edge as a CTRL read must not be lost.
            if (state_q == ST_RUN && done_0Ready) begin
                done_q <= 1'b1;
            end else if (rd_accept && rd_is_ctrl) begin
                done_q <= 1'b0;
            end

            if (rd_accept) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_is_ctrl ? ctrl_value : (rd_is_param ? rd_param_word : 32'h0);
                rresp_q  <= (rd_is_ctrl || rd_is_param) ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            if (wr_accept) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (wr_is_ctrl || param_wr_ok) ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            for (int i = 0; i < PARAM_WORDS; i++) begin
                if (param_wr_ok && param_index(wr_off) == 8'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_axi_wstrb[b]) params_q[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;

    sda_param_lookup_stage #(
        .PARAM_WORDS(PARAM_WORDS)
    ) u_lookup (
        .clk              (clk),
        .reset            (reset),
        .params           (params_q),
        .paramaddr_0Ready (paramaddr_0Ready),
        .paramaddr_0Stop  (paramaddr_0Stop),
        .paramaddr_0Data  (paramaddr_0Data),
        .paramdata_0Ready (paramdata_0Ready),
        .paramdata_0Stop  (paramdata_0Stop),
        .paramdata_0Data  (paramdata_0Data)
    );

endmodule

// File: doc/sda_kernel_param_regs.md
SDA_KERNEL_PARAM_REGS -- requirements
Module: sda_kernel_param_regs

Interface
REQ-001 SHALL have parameter PARAM_WORDS, default 16, giving the number of 32-bit kernel parameter registers (range 1..64).
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock
- reset  in  1  reset, asynchronous, active-low
- s_axi_araddr  in  32  read address
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake
- s_axi_awaddr  in  32  write address
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake
- go_0Ready / go_0Stop  out / in  1  start token to kernel
- done_0Ready / done_0Stop  in / out  1  completion token from kernel
- paramaddr_0Ready / paramaddr_0Stop  in / out  1  parameter lookup request
- paramaddr_0Data  in  32  parameter word index
- paramdata_0Ready / paramdata_0Stop  out / in  1  parameter lookup response
- paramdata_0Data  out  32  parameter value
REQ-003 SHALL treat a SELF transfer as occurring on a rising clk edge where Ready=1 and Stop=0.

Function
REQ-004 SHALL use this address map on bits [9:0], ignoring higher bits:
- 0x000 CTRL: bit0 START (write 1 sets), bit1 DONE (read-only, clear-on-read), bit2 IDLE (read-only)
- 0x010 + 4*i: PARAM[i], for i < PARAM_WORDS
REQ-005 SHALL return RRESP/BRESP 2'b10 (SLVERR) for unmapped addresses, with read data 0 and no state change; mapped accesses SHALL return 2'b00.
REQ-006 Read path SHALL assert arready only when no R beat is pending, present rdata/rvalid on the cycle after AR acceptance, and hold them until rready=1.
REQ-007 Write path SHALL assert awready and wready together, for one cycle, only when awvalid=1, wvalid=1 and no B beat is pending; it SHALL commit the write on that edge, honouring wstrb per byte, and raise bvalid on the next cycle, holding it until bready=1.
REQ-008 A PARAM write while IDLE=0 SHALL be discarded and answered with SLVERR.
REQ-009 The control FSM SHALL have three states: IDLE, GO and RUN.
- IDLE->GO on a CTRL write with wdata[0]=1 and wstrb[0]=1.
- GO: go_0Ready=1; GO->RUN on go transfer.
- RUN: done_0Stop=0; RUN->IDLE on done transfer, which sets DONE.
- In all other states done_0Stop=1.
REQ-010 IDLE SHALL read 1 only in state IDLE; START SHALL read 1 in state GO.
REQ-011 A CTRL START write outside IDLE SHALL be ignored with response OKAY.
REQ-012 A CTRL read SHALL clear DONE after the returned value is captured; if a done transfer occurs on the same edge, DONE SHALL remain 1.
REQ-013 A read and a write of the same register accepted on the same edge SHALL return the pre-write value.
REQ-014 Parameter lookup:
- paramaddr_0Stop = response_pending AND paramdata_0Stop.
- On request accept, paramdata_0Data = PARAM[paramaddr_0Data] if the index is below PARAM_WORDS, else 0, with paramdata_0Ready=1 on the next cycle.
- The response SHALL be held stable until transfer.
- Back-to-back throughput SHALL be one lookup per cycle.

Reset
REQ-015 While reset=0, all state SHALL clear immediately: FSM to IDLE, PARAM[*]=0, DONE=0, pending R/B/lookup flags cleared.
REQ-016 During and after reset, until the first event, outputs SHALL be:
- all ready/valid outputs, go_0Ready and paramdata_0Ready = 0
- done_0Stop = 1, paramaddr_0Stop = 0
- rdata, rresp, bresp, paramdata_0Data = 0
REQ-017 Reset asserted mid-transaction SHALL abandon that transaction without a response beat.

Structure
REQ-018 Package sda_kernel_param_pkg SHALL hold the CTRL/PARAM offsets, CTRL bit positions, RESP_OKAY/RESP_SLVERR, and the FSM state enum.
REQ-019 The lookup channel SHALL be a sub-module sda_param_lookup_stage: a one-entry SELF response register with a read port onto the parameter array.

Verification
REQ-020 Write 0x000000AB to 0x014 with wstrb=4'b0001 over a prior value 0x11223344 -> B OKAY; a read of 0x014 returns 0x112233AB.
REQ-021 Write CTRL=1 -> go_0Ready=1 until go_0Stop=0; hold done_0Ready=1 for 3 cycles in RUN -> CTRL reads 0x6, and a second read returns 0x4.
REQ-022 During RUN, write 0x010 -> SLVERR, and PARAM[0] is unchanged; a read of 0x3FC returns SLVERR with data 0.
REQ-023 Preload PARAM[2]=0xDEADBEEF, then issue lookups for indices 2, 2 and 99 with paramdata_0Stop=1 for 2 cycles -> responses 0xDEADBEEF, 0xDEADBEEF, 0, in order, with no loss.
REQ-024 Assert reset=0 while bvalid=1 and in state RUN -> bvalid=0, IDLE=1 and done_0Stop=1 immediately, without waiting for a clk edge.
